// File: rtl/cmd_mask_sequencer_1_8_pkg.sv
// Shared widths, state encoding and entry-width helper for the command-mask sequencer.
// Optional beat counter on the top is enabled with CMD_MASK_SEQ_BEAT_CNT_EN.
package cmd_mask_sequencer_1_8_pkg;

  localparam int NUM_OUTPUT_DATA = 8;
  localparam int LEN_WIDTH       = 4;
  localparam int FIFO_DEPTH      = 4;
  localparam int ENTRY_W         = NUM_OUTPUT_DATA + LEN_WIDTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic int entry_w(input int mask_w, input int len_w);
    return mask_w + len_w;
  endfunction

endpackage

// File: rtl/cmd_mask_sequencer_1_8_if.sv
// Command handshake bundle: mask + repeat length offered with valid, accepted with ready.
interface cmd_mask_sequencer_1_8_if
  import cmd_mask_sequencer_1_8_pkg::*;
#(
  parameter int NUM_OUTPUT_DATA = cmd_mask_sequencer_1_8_pkg::NUM_OUTPUT_DATA,
  parameter int LEN_WIDTH       = cmd_mask_sequencer_1_8_pkg::LEN_WIDTH
);
  logic                       i_valid;
  logic                       o_ready;
  logic [NUM_OUTPUT_DATA-1:0] i_cmd;
  logic [LEN_WIDTH-1:0]       i_len;

  modport master (output i_valid, output i_cmd, output i_len, input o_ready);
  modport slave  (input i_valid, input i_cmd, input i_len, output o_ready);
endinterface

// File: rtl/cmd_mask_sequencer_1_8_fifo.sv
// Synchronous command FIFO with flush; occupancy counter is one bit wider than the pointers.
module cmd_mask_fifo #(
  parameter int WIDTH = cmd_mask_sequencer_1_8_pkg::ENTRY_W,
  parameter int DEPTH = cmd_mask_sequencer_1_8_pkg::FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cmd_mask_sequencer_1_8.sv
// Replays queued destination masks as gap-free bursts for the 1-to-8 command tree.
// Define CMD_MASK_SEQ_BEAT_CNT_EN to add the o_beat_cnt issued-beat counter.
//
//   state    | meaning
//   ST_IDLE  | no command in progress, o_en=0
//   ST_BURST | replaying mask_q; rem_q beats remain after the current one
module cmd_mask_sequencer_1_8
  import cmd_mask_sequencer_1_8_pkg::*;
#(
  parameter int NUM_OUTPUT_DATA = cmd_mask_sequencer_1_8_pkg::NUM_OUTPUT_DATA,
  parameter int LEN_WIDTH       = cmd_mask_sequencer_1_8_pkg::LEN_WIDTH,
  parameter int FIFO_DEPTH      = cmd_mask_sequencer_1_8_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  cmd_mask_sequencer_1_8_if.slave    cmd_if,
  input  logic                       i_hold,
  input  logic                       i_flush,
  output logic                       o_en,
  output logic [NUM_OUTPUT_DATA-1:0] o_cmd,
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
  output logic [31:0]                o_beat_cnt,
`endif
  output logic                       o_busy
);
  localparam int EW = entry_w(NUM_OUTPUT_DATA, LEN_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [EW-1:0]              fifo_rdata;
  logic                       fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]              fifo_count;
  logic [NUM_OUTPUT_DATA-1:0] head_mask;
  logic [LEN_WIDTH-1:0]       head_len;

  state_e                     state_q, state_d;
  logic [NUM_OUTPUT_DATA-1:0] mask_q, mask_d;
  logic [LEN_WIDTH-1:0]       rem_q, rem_d;
  logic                       en_q, en_d;
  logic [NUM_OUTPUT_DATA-1:0] cmd_q, cmd_d;

  cmd_mask_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_if.i_valid),
    .pop_i   (fifo_pop),
    .flush_i (i_flush),
    .wdata_i ({cmd_if.i_cmd, cmd_if.i_len}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_mask      = fifo_rdata[EW-1:LEN_WIDTH];
  assign head_len       = fifo_rdata[LEN_WIDTH-1:0];
  assign cmd_if.o_ready = !fifo_full;
  assign o_busy         = (state_q == ST_BURST) || (fifo_count != '0);
  assign o_en           = en_q;
  assign o_cmd          = cmd_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    rem_d    = rem_q;
    en_d     = 1'b0;
    cmd_d    = '0;
    fifo_pop = 1'b0;
    if (i_flush) begin
      state_d = ST_IDLE;
    end else if (!i_hold) begin
      // A held edge neither consumes a beat nor retires the burst.
      if (state_q == ST_BURST && rem_q != '0) begin
        rem_d = rem_q - LEN_WIDTH'(1);
        en_d  = 1'b1;
        cmd_d = mask_q;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = ST_BURST;
        mask_d   = head_mask;
        rem_d    = head_len;
        en_d     = 1'b1;
        cmd_d    = head_mask;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      cmd_q   <= cmd_d;
    end
  end

`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) beat_cnt_q <= '0;
    else      beat_cnt_q <= beat_cnt_q + {31'd0, en_d};
  end

  assign o_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_mask_sequencer_1_8.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run
// against a queue-based beat-ownership model of the sequencer.
module tb_cmd_mask_sequencer_1_8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_hold = 1'b0;
  logic       i_flush = 1'b0;
  logic       o_en;
  logic       o_busy;
  logic [7:0] o_cmd;
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
  logic [31:0] o_beat_cnt;
`endif

  int checks = 0;
  int failures = 0;

  cmd_mask_sequencer_1_8_if tif ();

  cmd_mask_sequencer_1_8 dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_if     (tif),
    .i_hold     (i_hold),
    .i_flush    (i_flush),
    .o_en       (o_en),
    .o_cmd      (o_cmd),
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
    .o_beat_cnt (o_beat_cnt),
`endif
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted commands plus the number of beats
  // still owed by the command currently being replayed.
  logic [11:0] mq [$];
  bit          m_active;
  int          m_owed;
  logic [7:0]  m_mask;
  logic        m_en;
  int unsigned m_beats;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_owed   = 0;
    m_mask   = 8'h00;
    m_en     = 1'b0;
    m_beats  = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] c, input logic [3:0] l,
                            input logic h, input logic f);
    logic [11:0] e;
    bit accept;
    accept = v && (mq.size() < DEPTH) && !f;
    m_en = 1'b0;
    if (f) begin
      mq.delete();
      m_active = 1'b0;
      m_owed   = 0;
    end else begin
      if (!h) begin
        if (m_active && m_owed == 0) m_active = 1'b0;
        if (!m_active && mq.size() > 0) begin
          e        = mq.pop_front();
          m_mask   = e[11:4];
          m_owed   = int'(e[3:0]) + 1;
          m_active = 1'b1;
        end
        if (m_active) begin
          m_en = 1'b1;
          m_owed--;
        end
      end
      if (accept) mq.push_back({c, l});
    end
    if (m_en) m_beats++;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input logic v, input logic [7:0] c, input logic [3:0] l,
                      input logic h, input logic f);
    tif.i_valid = v;
    tif.i_cmd   = c;
    tif.i_len   = l;
    i_hold      = h;
    i_flush     = f;
    @(posedge clk);
    model_edge(v, c, l, h, f);
    #1;
    chk("model_en", o_en, m_en);
    chk("model_cmd", o_cmd, m_en ? m_mask : 8'h00);
    chk("model_busy", o_busy, (m_active || mq.size() != 0));
    chk("model_ready", tif.o_ready, (mq.size() < DEPTH));
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
    chk("model_beat_cnt", o_beat_cnt, m_beats);
`endif
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic [3:0] l;
    logic       h;
    logic       f;
    logic       en;
    logic [7:0] cmd;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0] got [$];
    logic [7:0] exp_full [4];
    int after;

    // Single command 81/len2, then back-to-back 01/0, 02/1, 04/0.
    tbl[0]  = '{1'b1, 8'h81, 4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 8'h01, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 8'h02, 4'd1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 8'h04, 4'd0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    exp_full = '{8'h11, 8'h22, 8'h33, 8'h44};

    tif.i_valid = 1'b0;
    tif.i_cmd   = 8'h00;
    tif.i_len   = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", o_en, 1'b0);
    chk("reset_cmd", o_cmd, 8'h00);
    chk("reset_busy", o_busy, 1'b0);
    rst = 1'b1;
    #1;
    chk("reset_ready", tif.o_ready, 1'b1);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].l, tbl[i].h, tbl[i].f);
      chk($sformatf("vec%0d_en", i), o_en, tbl[i].en);
      chk($sformatf("vec%0d_cmd", i), o_cmd, tbl[i].cmd);
      chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
      chk($sformatf("vec%0d_ready", i), tif.o_ready, tbl[i].rdy);
    end

    // Full FIFO under hold: four accepted, fifth refused.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h11 * (i + 1)), 4'd0, 1'b1, 1'b0);
      if (i == 3) chk("full_ready_after4", tif.o_ready, 1'b0);
    end
    chk("full_ready_after5", tif.o_ready, 1'b0);
    idle();
    chk("full_first_pop_ready", tif.o_ready, 1'b1);
    if (o_en) got.push_back(o_cmd);
    for (int k = 0; k < 20; k++) begin
      idle();
      if (o_en) got.push_back(o_cmd);
      else break;
    end
    chk("full_issue_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("full_order%0d", i), got[i], exp_full[i]);

    // Hold for three cycles after the second beat of a six-beat burst.
    step(1'b1, 8'hF0, 4'd5, 1'b0, 1'b0);
    idle();
    chk("hold_beat1", o_en, 1'b1);
    idle();
    chk("hold_beat2", o_cmd, 8'hF0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 4'd0, 1'b1, 1'b0);
      chk($sformatf("hold_gap%0d", k), o_en, 1'b0);
    end
    after = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (o_en && o_cmd == 8'hF0) after++;
      else break;
    end
    chk("hold_resume_beats", after, 4);

    // Flush with an active burst, two queued commands and a colliding push.
    step(1'b1, 8'hA0, 4'd3, 1'b0, 1'b0);
    step(1'b1, 8'hB0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 8'hC0, 4'd0, 1'b0, 1'b0);
    chk("flush_pre_busy", o_busy, 1'b1);
    step(1'b1, 8'h99, 4'd0, 1'b0, 1'b1);
    chk("flush_en", o_en, 1'b0);
    chk("flush_busy", o_busy, 1'b0);
    chk("flush_ready", tif.o_ready, 1'b1);
    idle();
    chk("flush_push_discarded", o_en, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 3));

    // Asynchronous reset in the middle of a burst.
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    step(1'b1, 8'h77, 4'd7, 1'b0, 1'b0);
    idle();
    idle();
    chk("rst_pre_en", o_en, 1'b1);
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
    chk("beat_cnt_total", o_beat_cnt, m_beats);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_en", o_en, 1'b0);
    chk("async_rst_cmd", o_cmd, 8'h00);
    chk("async_rst_busy", o_busy, 1'b0);
`ifdef CMD_MASK_SEQ_BEAT_CNT_EN
    chk("async_rst_beat_cnt", o_beat_cnt, 32'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", tif.o_ready, 1'b1);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_mask_sequencer_1_8.md
Name: cmd_mask_sequencer_1_8

Overview:
- Upstream feeder for the 1-to-8 sequential command binary tree. Drives that tree's i_en and 8-bit i_cmd destination mask every cycle.
- Accepts destination-mask commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each mask for a programmed number of beats, back-to-back with no bubbles, so the tree sees a gap-free command stream.

Parameters:
- NUM_OUTPUT_DATA, 8, width of the destination mask; must be a power of 2; matches the downstream tree.
- LEN_WIDTH, 4, width of the per-command repeat field; beats per command = len+1 (1..16).
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- i_valid  in  1  command valid
- o_ready  out  1  FIFO can accept a command
- i_cmd  in  NUM_OUTPUT_DATA  destination mask
- i_len  in  LEN_WIDTH  repeat count minus one
- i_hold  in  1  pause issue; burst counter frozen
- i_flush  in  1  synchronous abort: empty the FIFO, drop the current burst
- o_en  out  1  to tree i_en
- o_cmd  out  NUM_OUTPUT_DATA  to tree i_cmd
- o_busy  out  1  burst active or FIFO non-empty

Behaviour:
- Reset (rst=0, async): FIFO empty, rd/wr pointers 0, state IDLE, o_en=0, o_cmd=0, o_busy=0, o_ready=1 after release.
- Push occurs when i_valid && o_ready. {i_cmd, i_len} is written at the rising edge. o_ready = !full; it is registered-derived and does not depend on i_valid.
- Full FIFO: o_ready=0, no push. A same-cycle pop does not free a slot for a push in that cycle; there is no pass-through.
- FIFO occupancy counter is LEN-independent, width $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- State machine, 2 states:
  - IDLE: o_en=0, o_cmd=0. If FIFO non-empty and !i_hold and !i_flush: pop, load mask and remaining=len, go to BURST. o_en=1 and o_cmd=mask from the next cycle.
  - BURST: o_en=1, o_cmd=mask each cycle. At each edge with !i_hold, remaining decrements.
  - At the last beat (remaining==0): if the FIFO is non-empty, pop the next entry and stay in BURST; the first beat of the next command follows the last beat of the previous one directly. Otherwise go to IDLE.
- Latency: push at edge t into an empty FIFO while IDLE gives the first beat visible after edge t+1, i.e. 2 edges from push to o_en=1.
- i_hold=1: at the next edge o_en=0 and o_cmd=0, and remaining and state are frozen. On release, the burst resumes at the same remaining count; no beat is lost or duplicated. Pushes continue while held.
- i_flush=1: at the next edge the FIFO is emptied, state goes to IDLE, o_en=0, o_cmd=0. A push in the same cycle is discarded. Flush has priority over hold and push.
- Mask 0 is legal: issued as o_en=1, o_cmd=0 for len+1 beats.
- o_busy = (state==BURST) || (occupancy!=0).
- All outputs are registered except o_ready and o_busy, which are decoded from registers only.
- Reset mid-burst: immediate return to reset values. Any queued commands are lost.

Optional Feature:
- Macro CMD_MASK_SEQ_BEAT_CNT_EN.
- Defined: adds output o_beat_cnt [31:0]. It increments on every cycle o_en=1, wraps at 2^32, and is cleared by rst only (not by i_flush).
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package holds:
  - the NUM_OUTPUT_DATA default;
  - LEN_WIDTH;
  - the state encoding (IDLE=1'b0, BURST=1'b1);
  - the FIFO entry width NUM_OUTPUT_DATA+LEN_WIDTH.
- One natural sub-module: cmd_mask_fifo. It is a synchronous FIFO with push/pop, full/empty, occupancy, flush and async active-low reset. The sequencer instantiates it and adds the FSM and output registers.

Test Plan:
- Reset then single command: push i_cmd=8'h81, i_len=2 at edge 0. Required: o_en=1, o_cmd=8'h81 for exactly 3 cycles starting after edge 1, then o_en=0, o_cmd=0, o_busy=0.
- Back-to-back: push 8'h01/len 0, 8'h02/len 1, 8'h04/len 0 consecutively. Required: o_cmd sequence 01,02,02,04 on 4 consecutive cycles with o_en continuously 1.
- Full FIFO: hold i_hold=1 and push 5 commands. Required: o_ready=0 after 4 accepted pushes and the 5th is not accepted. Release hold: 4 commands issue in order, and o_ready=1 after the first pop.
- Hold mid-burst: 8'hF0/len 5, assert i_hold for 3 cycles after beat 2. Required: o_en=0 for 3 cycles, then exactly 4 further beats of 8'hF0 (6 total).
- Flush: 2 queued commands plus an active burst, assert i_flush for 1 cycle with i_valid=1. Required: o_en=0 next cycle, o_busy=0, the pushed command discarded, o_ready=1.
- Async reset mid-burst: drop rst low between edges. Required: o_en=0 and o_cmd=0 immediately, before the next edge. With CMD_MASK_SEQ_BEAT_CNT_EN defined: o_beat_cnt=0 after reset, and equal to the total issued beats after the previous scenarios.
